// File: rtl/aurora_pkg.sv
// rtl/aurora_pkg.sv - shared pipeline widths, MEM-stage FSM states and default timeout
package aurora_pkg;

    localparam int DWORD_W                = 64;
    localparam int REG_ADDR_W             = 5;
    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register bank with bubble insertion
module mem_wb_reg
    import aurora_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  bubble_i,
    input  logic                  reg_write_en_i,
    input  logic                  mem_to_reg_i,
    input  logic [DWORD_W-1:0]    mem_data_i,
    input  logic [DWORD_W-1:0]    alu_i,
    input  logic [REG_ADDR_W-1:0] reg_write_addr_i,
    output logic                  reg_write_en_o,
    output logic                  mem_to_reg_o,
    output logic [DWORD_W-1:0]    mem_data_o,
    output logic [DWORD_W-1:0]    alu_o,
    output logic [REG_ADDR_W-1:0] reg_write_addr_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || bubble_i) begin
            reg_write_en_o   <= 1'b0;
            mem_to_reg_o     <= 1'b0;
            mem_data_o       <= '0;
            alu_o            <= '0;
            reg_write_addr_o <= '0;
        end else begin
            reg_write_en_o   <= reg_write_en_i;
            mem_to_reg_o     <= mem_to_reg_i;
            mem_data_o       <= mem_data_i;
            alu_o            <= alu_i;
            reg_write_addr_o <= reg_write_addr_i;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: doubleword load/store FSM, watchdog abort, MEM/WB register
// Optional alignment trap: MEM_STAGE_MISALIGN_CHECK_EN
module mem_stage
    import aurora_pkg::*;
#(
    parameter int DMEM_ADDR_W    = 10,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reg_write_en_i,
    input  logic                   mem_write_en_i,
    input  logic                   mem_to_reg_i,
    input  logic [DWORD_W-1:0]     alu_i,
    input  logic [DWORD_W-1:0]     reg_data2_i,
    input  logic [REG_ADDR_W-1:0]  reg_write_addr_i,
    output logic                   stall_o,
    output logic                   dmem_req_o,
    output logic                   dmem_we_o,
    output logic [DMEM_ADDR_W-1:0] dmem_addr_o,
    output logic [DWORD_W-1:0]     dmem_wdata_o,
    input  logic [DWORD_W-1:0]     dmem_rdata_i,
    input  logic                   dmem_ack_i,
    output logic                   reg_write_en_o,
    output logic                   mem_to_reg_o,
    output logic [DWORD_W-1:0]     mem_data_o,
    output logic [DWORD_W-1:0]     alu_o,
    output logic [REG_ADDR_W-1:0]  reg_write_addr_o,
    output logic                   timeout_err_o,
    output logic                   misalign_o
);

    // Last WAIT cycle index; the abort fires when no ack arrives in it.
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

    mem_state_t         state;
    logic [15:0]        wait_cnt;
    logic               mem_op;
    logic               misalign;
    logic               issue;
    logic               bubble;
    logic [DWORD_W-1:0] load_data;

    assign mem_op = mem_write_en_i | mem_to_reg_i;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    assign misalign = mem_op & (alu_i[2:0] != 3'b000);
`else
    assign misalign = 1'b0;
`endif

    assign issue        = (state == IDLE) & mem_op & ~misalign;
    assign dmem_req_o   = ~rst_i & (issue | (state == WAIT));
    assign stall_o      = dmem_req_o & ~dmem_ack_i;
    assign dmem_we_o    = dmem_req_o & mem_write_en_i;
    assign dmem_addr_o  = alu_i[DMEM_ADDR_W+2:3];
    assign dmem_wdata_o = reg_data2_i;

    // A misaligned op is consumed without a request, so it must leave as a bubble too.
    assign bubble    = stall_o | (state == ABORT) | ((state == IDLE) & misalign);
    assign load_data = (mem_to_reg_i & ~mem_write_en_i) ? dmem_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            timeout_err_o <= 1'b0;
            misalign_o    <= 1'b0;
        end else begin
            misalign_o <= (state == IDLE) & misalign;
            case (state)
                IDLE: begin
                    if (issue && !dmem_ack_i) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (dmem_ack_i) begin
                        state <= IDLE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state         <= ABORT;
                        timeout_err_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ABORT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .bubble_i         (bubble),
        .reg_write_en_i   (reg_write_en_i),
        .mem_to_reg_i     (mem_to_reg_i),
        .mem_data_i       (load_data),
        .alu_i            (alu_i),
        .reg_write_addr_i (reg_write_addr_i),
        .reg_write_en_o   (reg_write_en_o),
        .mem_to_reg_o     (mem_to_reg_o),
        .mem_data_o       (mem_data_o),
        .alu_o            (alu_o),
        .reg_write_addr_o (reg_write_addr_o)
    );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage (TIMEOUT_CYCLES=4)
module tb_mem_stage;

    localparam int T  = 4;
    localparam int AW = 10;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic          reg_write_en_i, mem_write_en_i, mem_to_reg_i;
    logic [63:0]   alu_i, reg_data2_i, dmem_rdata_i;
    logic [4:0]    reg_write_addr_i;
    logic          stall_o, dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [AW-1:0] dmem_addr_o;
    logic [63:0]   dmem_wdata_o, mem_data_o, alu_o;
    logic          reg_write_en_o, mem_to_reg_o, timeout_err_o, misalign_o;
    logic [4:0]    reg_write_addr_o;

    int total = 0;
    int bad   = 0;
    bit err_exp = 1'b0;

    always #5 clk = ~clk;

    mem_stage #(.DMEM_ADDR_W(AW), .TIMEOUT_CYCLES(T)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .reg_write_en_i   (reg_write_en_i),
        .mem_write_en_i   (mem_write_en_i),
        .mem_to_reg_i     (mem_to_reg_i),
        .alu_i            (alu_i),
        .reg_data2_i      (reg_data2_i),
        .reg_write_addr_i (reg_write_addr_i),
        .stall_o          (stall_o),
        .dmem_req_o       (dmem_req_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_rdata_i     (dmem_rdata_i),
        .dmem_ack_i       (dmem_ack_i),
        .reg_write_en_o   (reg_write_en_o),
        .mem_to_reg_o     (mem_to_reg_o),
        .mem_data_o       (mem_data_o),
        .alu_o            (alu_o),
        .reg_write_addr_o (reg_write_addr_o),
        .timeout_err_o    (timeout_err_o),
        .misalign_o       (misalign_o)
    );

    // One EX/MEM op. lat = cycle offset of the ack (-1 = never). Expected behaviour:
    // the op finishes in cycle lat if lat<=T, otherwise it stalls T+1 cycles and aborts.
    task automatic do_op(input bit rwe, input bit mwe, input bit m2r, input logic [63:0] alu,
                         input logic [63:0] wd, input logic [4:0] wa, input int lat,
                         input logic [63:0] rd, input string tag);
        bit            mem     = mwe | m2r;
        bit            mis     = MIS_EN && mem && (alu[2:0] != 3'b000);
        bit            done_ok = !mem || mis || (lat >= 0 && lat <= T);
        int            final_c = (!mem || mis) ? 0 : (done_ok ? lat : T + 1);
        logic [AW-1:0] exp_addr = alu[AW+2:3];
        bit            exp_req, exp_stall;
        logic [63:0]   exp_data;
        reg_write_en_i   = rwe;
        mem_write_en_i   = mwe;
        mem_to_reg_i     = m2r;
        alu_i            = alu;
        reg_data2_i      = wd;
        reg_write_addr_i = wa;
        dmem_rdata_i     = rd;
        for (int c = 0; c <= final_c; c++) begin
            dmem_ack_i = (c == lat);
            #1;
            exp_req   = mem && !mis && (done_ok || c <= T);
            exp_stall = exp_req && (c != lat);
            total++;
            if (stall_o !== exp_stall) begin
                bad++; $display("FAIL %s stall c=%0d got=%b exp=%b", tag, c, stall_o, exp_stall);
            end
            total++;
            if (dmem_req_o !== exp_req) begin
                bad++; $display("FAIL %s req c=%0d got=%b exp=%b", tag, c, dmem_req_o, exp_req);
            end
            if (exp_req) begin
                total++;
                if (dmem_addr_o !== exp_addr || dmem_we_o !== mwe || dmem_wdata_o !== wd) begin
                    bad++;
                    $display("FAIL %s dmem c=%0d got addr=%h we=%b wd=%h exp addr=%h we=%b wd=%h",
                             tag, c, dmem_addr_o, dmem_we_o, dmem_wdata_o, exp_addr, mwe, wd);
                end
            end
            @(posedge clk); #1;
            if (c < final_c) begin
                total++;
                if (reg_write_en_o !== 1'b0 || mem_to_reg_o !== 1'b0 || alu_o !== 64'h0) begin
                    bad++;
                    $display("FAIL %s bubble c=%0d got rwe=%b m2r=%b alu=%h exp 0", tag, c,
                             reg_write_en_o, mem_to_reg_o, alu_o);
                end
            end
        end
        if (!done_ok) err_exp = 1'b1;
        exp_data = (m2r && !mwe) ? rd : 64'h0;
        if (!done_ok || mis) begin
            total++;
            if ({reg_write_en_o, mem_to_reg_o, mem_data_o, alu_o, reg_write_addr_o} !== '0) begin
                bad++;
                $display("FAIL %s wb_bubble got rwe=%b m2r=%b data=%h alu=%h wa=%0d exp all 0",
                         tag, reg_write_en_o, mem_to_reg_o, mem_data_o, alu_o, reg_write_addr_o);
            end
        end else begin
            total++;
            if (reg_write_en_o !== rwe || mem_to_reg_o !== m2r || reg_write_addr_o !== wa) begin
                bad++;
                $display("FAIL %s wb_ctrl got rwe=%b m2r=%b wa=%0d exp rwe=%b m2r=%b wa=%0d", tag,
                         reg_write_en_o, mem_to_reg_o, reg_write_addr_o, rwe, m2r, wa);
            end
            total++;
            if (alu_o !== alu || mem_data_o !== exp_data) begin
                bad++;
                $display("FAIL %s wb_data got alu=%h data=%h exp alu=%h data=%h", tag, alu_o,
                         mem_data_o, alu, exp_data);
            end
        end
        total++;
        if (misalign_o !== mis) begin
            bad++; $display("FAIL %s misalign got=%b exp=%b", tag, misalign_o, mis);
        end
        total++;
        if (timeout_err_o !== err_exp) begin
            bad++; $display("FAIL %s timeout_err got=%b exp=%b", tag, timeout_err_o, err_exp);
        end
        dmem_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        mem_to_reg_i = 1'b1; reg_write_en_i = 1'b1; alu_i = 64'h40;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            bad++; $display("FAIL reset_comb got req=%b stall=%b exp 0", dmem_req_o, stall_o);
        end
        total++;
        if ({reg_write_en_o, mem_to_reg_o, mem_data_o, alu_o, reg_write_addr_o,
             timeout_err_o, misalign_o} !== '0) begin
            bad++; $display("FAIL reset_regs got rwe=%b m2r=%b alu=%h err=%b exp all 0",
                            reg_write_en_o, mem_to_reg_o, alu_o, timeout_err_o);
        end
        mem_to_reg_i = 1'b0; reg_write_en_i = 1'b0; alu_i = '0;
        rst_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_nonmem();
        do_op(1, 0, 0, 64'h1234, 64'h0, 5'd5, -1, 64'h0, "nonmem");
        do_op(1, 0, 0, 64'hFFFF_0000_1111_2227, 64'h55, 5'd31, 0, 64'h99, "nonmem_stray_ack");
    endtask

    task automatic test_load_wait();
        do_op(1, 0, 1, 64'h40, 64'h0, 5'd7, 3, 64'hDEADBEEF, "load_wait3");
    endtask

    task automatic test_store_zero();
        do_op(1, 1, 0, 64'h18, 64'hAA, 5'd3, 0, 64'h1357, "store_zero");
        do_op(1, 1, 1, 64'h20, 64'hBB, 5'd4, 1, 64'h2468, "store_and_m2r");
    endtask

    task automatic test_misalign();
        do_op(1, 0, 1, 64'h43, 64'h0, 5'd9, 0, 64'hCAFE, "misalign_load");
    endtask

    task automatic test_timeout();
        do_op(1, 0, 1, 64'h100, 64'h0, 5'd2, T, 64'h77, "ack_at_limit");
        do_op(1, 0, 1, 64'h108, 64'h0, 5'd2, -1, 64'h0, "timeout");
        do_op(1, 1, 0, 64'h110, 64'h5A, 5'd6, T + 1, 64'h0, "timeout_late_ack");
        do_op(1, 0, 1, 64'h118, 64'h0, 5'd8, 2, 64'h4242, "after_timeout");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            int          kind = $urandom_range(0, 3);
            int          r    = $urandom_range(0, 11);
            int          lat;
            logic [63:0] a    = {$urandom, $urandom};
            if (MIS_EN && $urandom_range(0, 3) != 0) a[2:0] = 3'b000;
            if (r <= T)       lat = r;
            else if (r <= 8)  lat = $urandom_range(0, 2);
            else if (r == 9)  lat = -1;
            else if (r == 10) lat = T + 1;
            else              lat = 0;
            do_op(1'($urandom_range(0, 1)), kind[1], kind[0] | (kind == 3), a,
                  {$urandom, $urandom}, 5'($urandom), lat, {$urandom, $urandom}, "random");
        end
    endtask

    task automatic test_reset_in_wait();
        reg_write_en_i = 1'b1; mem_to_reg_i = 1'b1; mem_write_en_i = 1'b0;
        alu_i = 64'h80; reg_write_addr_i = 5'd12; dmem_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b1;
        #1;
        total++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            bad++; $display("FAIL rst_wait_comb got req=%b stall=%b exp 0", dmem_req_o, stall_o);
        end
        @(posedge clk); #1;
        total++;
        if ({reg_write_en_o, mem_to_reg_o, mem_data_o, alu_o, reg_write_addr_o,
             timeout_err_o, misalign_o} !== '0) begin
            bad++; $display("FAIL rst_wait_regs got rwe=%b m2r=%b alu=%h err=%b exp all 0",
                            reg_write_en_o, mem_to_reg_o, alu_o, timeout_err_o);
        end
        err_exp = 1'b0;
        reg_write_en_i = 1'b0; mem_to_reg_i = 1'b0; alu_i = '0; reg_write_addr_i = '0;
        rst_i = 1'b0;
        @(posedge clk); #1;
        do_op(1, 0, 1, 64'h88, 64'h0, 5'd13, 1, 64'hABCD, "after_reset");
    endtask

    initial begin
        rst_i = 1'b1;
        reg_write_en_i = 1'b0; mem_write_en_i = 1'b0; mem_to_reg_i = 1'b0;
        alu_i = '0; reg_data2_i = '0; reg_write_addr_i = '0;
        dmem_rdata_i = '0; dmem_ack_i = 1'b0;
        test_reset();
        test_nonmem();
        test_load_wait();
        test_store_zero();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 64-bit five-stage pipeline, between the EX/MEM pipeline register and write-back. Consumes the EX/MEM control and data fields and performs doubleword loads and stores over a ready/acknowledge data-memory handshake. Stalls upstream while an access is outstanding and registers the MEM/WB fields for write-back. A watchdog aborts accesses that never acknowledge.

## Interface
Parameters:
- DMEM_ADDR_W, 10: doubleword address width; dmem_addr_o = alu_i[DMEM_ADDR_W+2:3]
- TIMEOUT_CYCLES, 255: maximum wait cycles before abort; range 1..65535

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset; synchronous and active-high
- reg_write_en_i  in  1  EX/MEM register-write enable
- mem_write_en_i  in  1  EX/MEM store request
- mem_to_reg_i  in  1  EX/MEM load request (write-back selects memory data)
- alu_i  in  64  effective address or ALU result
- reg_data2_i  in  64  store data
- reg_write_addr_i  in  5  destination register
- stall_o  out  1  combinational; upstream holds EX/MEM while high
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  DMEM_ADDR_W  doubleword address
- dmem_wdata_o  out  64  write data
- dmem_rdata_i  in  64  read data, valid with ack
- dmem_ack_i  in  1  access complete
- reg_write_en_o  out  1  MEM/WB write enable
- mem_to_reg_o  out  1  MEM/WB select
- mem_data_o  out  64  load data
- alu_o  out  64  ALU result passthrough
- reg_write_addr_o  out  5  MEM/WB destination
- timeout_err_o  out  1  sticky abort flag
- misalign_o  out  1  one-cycle misalignment pulse (see Configuration)

## Operation
- mem_op = mem_write_en_i | mem_to_reg_i. If both are set, the access is a store (dmem_we_o=1); mem_to_reg is still forwarded.
- Non-memory op: no request. MEM/WB fields load from the inputs at the next edge. mem_data_o loads 0.
- FSM states:
  - IDLE, with mem_op: dmem_req_o=1 combinationally; address and data are taken directly from the inputs, which upstream holds stable under stall. Ack in the same cycle completes the access; otherwise go to WAIT.
  - WAIT: dmem_req_o stays 1 with the same address and data. On ack, complete and go to IDLE. Each cycle increments a 16-bit wait counter.
  - ABORT: entered from WAIT when the counter reaches TIMEOUT_CYCLES. Drops the request, sets timeout_err_o, and completes as a bubble. Returns to IDLE on the next cycle.
- stall_o = mem_op & !dmem_ack_i in IDLE; 1 in WAIT; 0 in ABORT.
- While stalled, the MEM/WB outputs load a bubble at each edge: reg_write_en_o=0, mem_to_reg_o=0, others 0.
- On completion, the MEM/WB fields load the inputs. mem_data_o loads dmem_rdata_i for loads and 0 for stores.
- timeout_err_o stays set until reset. Later accesses run normally.
- An ack seen in IDLE without mem_op is ignored.

## Timing
- Reset (rst_i high at an edge): state IDLE, counter 0, all registered outputs 0, timeout_err_o 0. dmem_req_o depends only on state and inputs; during the reset cycle it is forced to 0.
- Reset asserted in WAIT: the request is dropped the same cycle, with no completion and no write-back.
- Zero-wait memory (ack in the request cycle): latency 1 cycle, no stall. Same as a non-memory op.
- N wait cycles (ack N cycles after the first request): stall for N cycles; MEM/WB valid N+1 edges after the op first appears.
- Abort: stall for TIMEOUT_CYCLES+1 cycles, then one bubble.
- An ack arriving in the same cycle the counter reaches TIMEOUT_CYCLES takes priority over the abort.

## Configuration
- MEM_STAGE_MISALIGN_CHECK_EN defined:
  - A mem_op with alu_i[2:0] != 0 issues no request and does not stall.
  - It completes next edge as a bubble (reg_write_en_o=0) and misalign_o pulses 1 for that cycle.
- Undefined: alu_i[2:0] are ignored and misalign_o is tied 0.

## Structure
- Shared package aurora_pkg holds:
  - DWORD_W=64 and REG_ADDR_W=5
  - the FSM state typedef (IDLE, WAIT, ABORT)
  - the default TIMEOUT_CYCLES value
- Sub-module mem_wb_reg: the MEM/WB register bank, with synchronous reset and a bubble-insert input driven by stall/abort. The FSM and watchdog stay in mem_stage.

## Test plan
- Non-memory op, alu_i=0x1234, reg_write_addr_i=5, reg_write_en_i=1 -> next edge alu_o=0x1234, reg_write_addr_o=5, reg_write_en_o=1; stall_o never high.
- Load at alu_i=0x40, ack 3 cycles later with rdata=0xDEADBEEF -> dmem_addr_o=8 and stall_o high for 3 cycles with bubbles meanwhile; then mem_data_o=0xDEADBEEF, mem_to_reg_o=1.
- Store at alu_i=0x18, data 0xAA, same-cycle ack -> dmem_we_o=1, dmem_addr_o=3, dmem_wdata_o=0xAA, no stall, mem_data_o=0.
- TIMEOUT_CYCLES=4, load with ack never asserted -> stall for 5 cycles, dmem_req_o drops, timeout_err_o=1 and stays 1, reg_write_en_o=0.
- rst_i pulsed in WAIT -> dmem_req_o and stall_o 0 the same cycle; all outputs 0 after the edge.
- With MEM_STAGE_MISALIGN_CHECK_EN, load at alu_i=0x43 -> no dmem_req_o, misalign_o pulses 1, reg_write_en_o=0.
